// File: rtl/gshare_ras_ongorucu.sv
// gshare direction predictor with a BTB of counters/targets and a circular return stack.
// Predictions are registered one cycle after the request; execute trains and repairs via checkpoints.
module gshare_ras_ongorucu #(
  parameter int ADR_BIT      = 32,
  parameter int BTB_DERINLIK = 32,
  parameter int GHR_BIT      = 8,
  parameter int RAS_DERINLIK = 4,
  localparam int IDX = $clog2(BTB_DERINLIK),
  localparam int RP  = $clog2(RAS_DERINLIK)
) (
  input  logic               clk_g,
  input  logic               rst_g,
  input  logic               i_gecerli,
  input  logic [ADR_BIT-1:0] i_buyruk_adresi,
  input  logic               i_is_branch,
  input  logic               i_is_jal,
  input  logic               i_is_jalr,
  input  logic               i_is_call,
  input  logic               i_is_ret,
  input  logic               i_is_comp,
  input  logic [ADR_BIT-1:0] i_jal_hedef,
  output logic               o_gecerli,
  output logic               o_buyruk_ongoru,
  output logic [ADR_BIT-1:0] o_atlanan_adres,
  output logic [GHR_BIT-1:0] o_ghr_ckpt,
  output logic [RP:0]        o_ras_ckpt,
  input  logic               i_guncelle_gecerli,
  input  logic [ADR_BIT-1:0] i_g_adres,
  input  logic               i_g_branch,
  input  logic               i_g_jalr,
  input  logic               i_g_atladi,
  input  logic [ADR_BIT-1:0] i_g_hedef,
  input  logic               i_g_yanlis,
  input  logic [GHR_BIT-1:0] i_g_ghr_ckpt,
  input  logic [RP:0]        i_g_ras_ckpt
);

  localparam logic [RP:0]   RAS_FULL = RAS_DERINLIK[RP:0];
  localparam logic [RP-1:0] PTR_ONE  = RP'(1);
  localparam logic [RP:0]   CNT_ONE  = (RP+1)'(1);

  logic [1:0]         ctr        [BTB_DERINLIK];
  logic               btb_valid  [BTB_DERINLIK];
  logic [ADR_BIT-1:0] btb_target [BTB_DERINLIK];
  logic [GHR_BIT-1:0] ghr;
  logic [ADR_BIT-1:0] ras        [RAS_DERINLIK];
  logic [RP-1:0]      ras_ptr;
  logic [RP:0]        ras_cnt;

  logic [IDX-1:0]     p_idx, u_idx;
  logic [ADR_BIT-1:0] fall_thru, p_target;
  logic               p_taken, fire, repair, pop_ok;
  logic [RP-1:0]      ptr_pop, ptr_nxt;
  logic [RP:0]        cnt_pop, cnt_nxt;
  logic               unused_ok;

  assign repair    = i_guncelle_gecerli & i_g_yanlis;
  assign fire      = i_gecerli & ~repair;
  assign p_idx     = i_buyruk_adresi[IDX+1:2] ^ ghr[IDX-1:0];
  assign u_idx     = i_g_adres[IDX+1:2] ^ i_g_ghr_ckpt[IDX-1:0];
  assign fall_thru = i_buyruk_adresi + {{(ADR_BIT-3){1'b0}}, ~i_is_comp, i_is_comp, 1'b0};
  assign unused_ok = ^{i_g_adres[ADR_BIT-1:IDX+2], i_g_adres[1:0]};

  always_comb begin
    p_taken  = 1'b0;
    p_target = fall_thru;
    if (i_is_branch) begin
      if (btb_valid[p_idx] && ctr[p_idx][1]) begin
        p_taken  = 1'b1;
        p_target = btb_target[p_idx];
      end
    end else if (i_is_jal) begin
      p_taken  = 1'b1;
      p_target = i_jal_hedef;
    end else if (i_is_jalr) begin
      if (i_is_ret && ras_cnt != '0) begin
        p_taken  = 1'b1;
        p_target = ras[ras_ptr];
      end else if (btb_valid[p_idx]) begin
        p_taken  = 1'b1;
        p_target = btb_target[p_idx];
      end
    end
  end

  // Pop happens before push, so call+ret rewrites the current top in place.
  always_comb begin
    pop_ok  = i_is_ret && (ras_cnt != '0);
    ptr_pop = pop_ok ? ras_ptr - PTR_ONE : ras_ptr;
    cnt_pop = pop_ok ? ras_cnt - CNT_ONE : ras_cnt;
    ptr_nxt = ptr_pop;
    cnt_nxt = cnt_pop;
    if (i_is_call) begin
      ptr_nxt = ptr_pop + PTR_ONE;
      if (cnt_pop != RAS_FULL) cnt_nxt = cnt_pop + CNT_ONE;
    end
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      for (int i = 0; i < BTB_DERINLIK; i++) begin
        ctr[i]        <= 2'b01;
        btb_valid[i]  <= 1'b0;
        btb_target[i] <= '0;
      end
      for (int i = 0; i < RAS_DERINLIK; i++) ras[i] <= '0;
      ghr             <= '0;
      ras_ptr         <= '0;
      ras_cnt         <= '0;
      o_gecerli       <= 1'b0;
      o_buyruk_ongoru <= 1'b0;
      o_atlanan_adres <= '0;
      o_ghr_ckpt      <= '0;
      o_ras_ckpt      <= '0;
    end else begin
      if (i_guncelle_gecerli) begin
        if (i_g_branch) begin
          if (i_g_atladi && ctr[u_idx] != 2'b11)
            ctr[u_idx] <= ctr[u_idx] + 2'b01;
          else if (!i_g_atladi && ctr[u_idx] != 2'b00)
            ctr[u_idx] <= ctr[u_idx] - 2'b01;
        end
        if (i_g_atladi || i_g_jalr) begin
          btb_target[u_idx] <= i_g_hedef;
          btb_valid[u_idx]  <= 1'b1;
        end
      end

      // The checkpoint keeps only "non-empty"; a restored non-empty stack is treated as full.
      if (repair) begin
        ghr     <= i_g_branch ? {i_g_ghr_ckpt[GHR_BIT-2:0], i_g_atladi} : i_g_ghr_ckpt;
        ras_ptr <= i_g_ras_ckpt[RP:1];
        ras_cnt <= i_g_ras_ckpt[0] ? RAS_FULL : '0;
      end else if (fire) begin
        if (i_is_branch) ghr <= {ghr[GHR_BIT-2:0], p_taken};
        if (i_is_call) ras[ptr_nxt] <= fall_thru;
        ras_ptr <= ptr_nxt;
        ras_cnt <= cnt_nxt;
      end

      o_gecerli <= fire;
      if (fire) begin
        o_buyruk_ongoru <= p_taken;
        o_atlanan_adres <= p_target;
        o_ghr_ckpt      <= ghr;
        o_ras_ckpt      <= {ras_ptr, ras_cnt != '0};
      end
    end
  end

endmodule

// File: tb/tb_gshare_ras_ongorucu.sv
// Scoreboard bench for gshare_ras_ongorucu: directed scenarios plus random traffic
// against an array-based reference model; a negedge monitor pops and compares outputs.
module tb_gshare_ras_ongorucu;

  localparam int BD = 32;
  localparam int RD = 4;

  logic        clk_g = 1'b0;
  logic        rst_g = 1'b0;
  logic        i_gecerli, i_is_branch, i_is_jal, i_is_jalr, i_is_call, i_is_ret, i_is_comp;
  logic [31:0] i_buyruk_adresi, i_jal_hedef;
  logic        o_gecerli, o_buyruk_ongoru;
  logic [31:0] o_atlanan_adres;
  logic [7:0]  o_ghr_ckpt;
  logic [2:0]  o_ras_ckpt;
  logic        i_guncelle_gecerli, i_g_branch, i_g_jalr, i_g_atladi, i_g_yanlis;
  logic [31:0] i_g_adres, i_g_hedef;
  logic [7:0]  i_g_ghr_ckpt;
  logic [2:0]  i_g_ras_ckpt;

  gshare_ras_ongorucu dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .i_gecerli(i_gecerli), .i_buyruk_adresi(i_buyruk_adresi),
    .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
    .i_is_call(i_is_call), .i_is_ret(i_is_ret), .i_is_comp(i_is_comp),
    .i_jal_hedef(i_jal_hedef),
    .o_gecerli(o_gecerli), .o_buyruk_ongoru(o_buyruk_ongoru),
    .o_atlanan_adres(o_atlanan_adres), .o_ghr_ckpt(o_ghr_ckpt), .o_ras_ckpt(o_ras_ckpt),
    .i_guncelle_gecerli(i_guncelle_gecerli), .i_g_adres(i_g_adres),
    .i_g_branch(i_g_branch), .i_g_jalr(i_g_jalr), .i_g_atladi(i_g_atladi),
    .i_g_hedef(i_g_hedef), .i_g_yanlis(i_g_yanlis),
    .i_g_ghr_ckpt(i_g_ghr_ckpt), .i_g_ras_ckpt(i_g_ras_ckpt)
  );

  always #5 clk_g = ~clk_g;

  typedef struct {
    logic v; logic [31:0] pc; logic br, jal, jalr, call, ret, comp; logic [31:0] jh;
  } req_t;
  typedef struct {
    logic v; logic [31:0] adr; logic br, jalr, atladi, yanlis; logic [31:0] hedef;
    logic [7:0] ghr; logic [2:0] ras;
  } upd_t;
  typedef struct {
    logic taken; logic [31:0] tgt; logic [7:0] ghr; logic [2:0] ras; string name;
  } exp_t;
  typedef struct { req_t r; logic [7:0] ghr; logic [2:0] ras; } rec_t;

  exp_t sb[$];
  rec_t hist[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int          m_ctr [BD];
  bit          m_val [BD];
  logic [31:0] m_tgt [BD];
  logic [31:0] m_ras [RD];
  logic [7:0]  m_ghr;
  int          m_top, m_cnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic modelReset();
    for (int i = 0; i < BD; i++) begin m_ctr[i] = 1; m_val[i] = 0; m_tgt[i] = '0; end
    for (int i = 0; i < RD; i++) m_ras[i] = '0;
    m_ghr = '0; m_top = 0; m_cnt = 0;
  endtask

  function automatic int slotOf(input logic [31:0] pc, input logic [7:0] h);
    return int'(((pc >> 2) ^ {24'h0, h}) % BD);
  endfunction

  function automatic req_t mkReq(input logic [31:0] pc, input logic br, jal, jalr, call, ret, comp,
                                 input logic [31:0] jh);
    req_t r;
    r.v = 1'b1; r.pc = pc; r.br = br; r.jal = jal; r.jalr = jalr;
    r.call = call; r.ret = ret; r.comp = comp; r.jh = jh;
    return r;
  endfunction

  function automatic req_t idleReq();
    req_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic upd_t mkUpd(input logic [31:0] adr, input logic br, jalr, atladi,
                                 input logic [31:0] hedef, input logic yanlis,
                                 input logic [7:0] ghr, input logic [2:0] ras);
    upd_t u;
    u.v = 1'b1; u.adr = adr; u.br = br; u.jalr = jalr; u.atladi = atladi;
    u.hedef = hedef; u.yanlis = yanlis; u.ghr = ghr; u.ras = ras;
    return u;
  endfunction

  function automatic upd_t noUpd();
    upd_t u;
    u = '{default: '0};
    return u;
  endfunction

  task automatic idleInputs();
    i_gecerli = 0; i_buyruk_adresi = '0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
    i_is_call = 0; i_is_ret = 0; i_is_comp = 0; i_jal_hedef = '0;
    i_guncelle_gecerli = 0; i_g_adres = '0; i_g_branch = 0; i_g_jalr = 0; i_g_atladi = 0;
    i_g_hedef = '0; i_g_yanlis = 0; i_g_ghr_ckpt = '0; i_g_ras_ckpt = '0;
  endtask

  // Drives one cycle; the model predicts from pre-cycle state, then applies update, repair and speculation.
  task automatic applyStimulus(input req_t r, input upd_t u, input string name,
                               input bit chkT = 1'b0, input logic expTaken = 1'b0,
                               input logic [31:0] expTgt = 32'h0,
                               input bit chkG = 1'b0, input logic [7:0] expGhr = 8'h0);
    exp_t        e;
    rec_t        h;
    int          idx, ui;
    logic        t, fired;
    logic [31:0] tg, ra;
    i_gecerli = r.v; i_buyruk_adresi = r.pc; i_is_branch = r.br; i_is_jal = r.jal;
    i_is_jalr = r.jalr; i_is_call = r.call; i_is_ret = r.ret; i_is_comp = r.comp;
    i_jal_hedef = r.jh;
    i_guncelle_gecerli = u.v; i_g_adres = u.adr; i_g_branch = u.br; i_g_jalr = u.jalr;
    i_g_atladi = u.atladi; i_g_hedef = u.hedef; i_g_yanlis = u.yanlis;
    i_g_ghr_ckpt = u.ghr; i_g_ras_ckpt = u.ras;

    fired = r.v && !(u.v && u.yanlis);
    idx = slotOf(r.pc, m_ghr);
    ra  = r.pc + (r.comp ? 32'd2 : 32'd4);
    t = 1'b0; tg = ra;
    if (r.br) begin
      if (m_val[idx] && m_ctr[idx] >= 2) begin t = 1'b1; tg = m_tgt[idx]; end
    end else if (r.jal) begin
      t = 1'b1; tg = r.jh;
    end else if (r.jalr) begin
      if (r.ret && m_cnt > 0) begin t = 1'b1; tg = m_ras[m_top]; end
      else if (m_val[idx]) begin t = 1'b1; tg = m_tgt[idx]; end
    end
    if (fired) begin
      e.taken = chkT ? expTaken : t;
      e.tgt   = chkT ? expTgt : tg;
      e.ghr   = chkG ? expGhr : m_ghr;
      e.ras   = 3'(m_top * 2 + ((m_cnt > 0) ? 1 : 0));
      e.name  = name;
      sb.push_back(e);
      h.r = r; h.ghr = m_ghr; h.ras = e.ras;
      hist.push_back(h);
    end

    if (u.v) begin
      ui = slotOf(u.adr, u.ghr);
      if (u.br) m_ctr[ui] = u.atladi ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3)
                                     : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
      if (u.atladi || u.jalr) begin m_tgt[ui] = u.hedef; m_val[ui] = 1; end
      if (u.yanlis) begin
        m_ghr = u.br ? {u.ghr[6:0], u.atladi} : u.ghr;
        m_top = int'(u.ras[2:1]);
        m_cnt = u.ras[0] ? RD : 0;
      end
    end
    if (fired) begin
      if (r.br) m_ghr = {m_ghr[6:0], t};
      if (r.ret && m_cnt > 0) begin m_top = (m_top + RD - 1) % RD; m_cnt--; end
      if (r.call) begin
        m_top = (m_top + 1) % RD;
        m_ras[m_top] = ra;
        if (m_cnt < RD) m_cnt++;
      end
    end

    @(posedge clk_g); #1;
    idleInputs();
  endtask

  always @(negedge clk_g) begin
    exp_t e;
    if (rst_g && o_gecerli) begin
      if (sb.size() == 0) checkOutput("unexpected_valid", 64'(o_gecerli), 64'd0);
      else begin
        e = sb.pop_front();
        checkOutput({e.name, ".taken"},  64'(o_buyruk_ongoru), 64'(e.taken));
        checkOutput({e.name, ".target"}, 64'(o_atlanan_adres), 64'(e.tgt));
        checkOutput({e.name, ".ghr"},    64'(o_ghr_ckpt),      64'(e.ghr));
        checkOutput({e.name, ".ras"},    64'(o_ras_ckpt),      64'(e.ras));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"},  64'(o_gecerli),       64'd0);
    checkOutput({tag, ".taken"},  64'(o_buyruk_ongoru), 64'd0);
    checkOutput({tag, ".target"}, 64'(o_atlanan_adres), 64'd0);
    checkOutput({tag, ".ghr"},    64'(o_ghr_ckpt),      64'd0);
    checkOutput({tag, ".ras"},    64'(o_ras_ckpt),      64'd0);
  endtask

  initial begin
    req_t r;
    upd_t u;
    rec_t h;
    int   kind;
    idleInputs();
    modelReset();
    repeat (2) @(posedge clk_g);
    #1 checkAllZero("reset");
    @(negedge clk_g) rst_g = 1'b1;
    @(posedge clk_g); #1;

    $display("[TB] first branch and training");
    applyStimulus(mkReq(32'h100, 1,0,0,0,0,0, 0), noUpd(), "first_branch", 1, 0, 32'h104, 1, 8'h00);
    repeat (2) applyStimulus(idleReq(), mkUpd(32'h100, 1, 0, 1, 32'h180, 0, 8'h00, 3'd0), "train");
    applyStimulus(mkReq(32'h100, 1,0,0,0,0,0, 0), noUpd(), "trained_branch", 1, 1, 32'h180, 1, 8'h00);

    $display("[TB] return stack overflow and underflow");
    for (int k = 1; k <= 5; k++)
      applyStimulus(mkReq(32'(k * 16), 0,1,0,1,0,0, 32'h1000), noUpd(), "call", 1, 1, 32'h1000);
    applyStimulus(mkReq(32'h2000, 0,0,1,0,1,0, 0), noUpd(), "ret1", 1, 1, 32'h54);
    applyStimulus(mkReq(32'h2000, 0,0,1,0,1,0, 0), noUpd(), "ret2", 1, 1, 32'h44);
    applyStimulus(mkReq(32'h2000, 0,0,1,0,1,0, 0), noUpd(), "ret3", 1, 1, 32'h34);
    applyStimulus(mkReq(32'h2000, 0,0,1,0,1,0, 0), noUpd(), "ret4", 1, 1, 32'h24);
    applyStimulus(mkReq(32'h2000, 0,0,1,0,1,0, 0), noUpd(), "ret_empty", 1, 0, 32'h2004);

    $display("[TB] mispredict repair with concurrent request");
    applyStimulus(mkReq(32'h500, 1,0,0,0,0,0, 0),
                  mkUpd(32'h700, 1, 0, 1, 32'h740, 1, 8'hA5, 3'd0), "suppressed");
    checkOutput("suppressed_valid", 64'(o_gecerli), 64'd0);
    applyStimulus(mkReq(32'h100, 1,0,0,0,0,0, 0), noUpd(), "after_repair", 0, 0, 0, 1, 8'h4B);

    $display("[TB] compressed call and direct jump");
    applyStimulus(mkReq(32'h200, 0,0,1,1,0,1, 0), noUpd(), "c_jalr_call");
    applyStimulus(mkReq(32'h300, 0,1,0,0,0,0, 32'h400), noUpd(), "jal", 1, 1, 32'h400, 1, 8'h96);
    applyStimulus(mkReq(32'h210, 0,0,1,0,1,0, 0), noUpd(), "ret_comp", 1, 1, 32'h202, 1, 8'h96);

    $display("[TB] random traffic");
    hist.delete();
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 8));
      r = mkReq(32'($urandom_range(0, 1023)) << 1, 0,0,0,0,0,0, 32'($urandom) & 32'hFFFF_FFFE);
      r.v    = ($urandom_range(0, 9) < 8);
      r.comp = 1'($urandom_range(0, 1));
      case (kind)
        1: r.br = 1;
        2: r.jal = 1;
        3: r.jalr = 1;
        4: begin r.jalr = 1; r.ret = 1; end
        5: begin r.jal = 1; r.call = 1; end
        6: begin r.jalr = 1; r.call = 1; r.ret = 1; end
        7: begin r.jalr = 1; r.call = 1; end
        8: begin r.br = 1; r.jal = 1; end
        default: ;
      endcase
      u = noUpd();
      if (hist.size() > 0 && $urandom_range(0, 9) < 4) begin
        h = hist.pop_front();
        u = mkUpd(h.r.pc, h.r.br, !h.r.br && !h.r.jal && h.r.jalr, 1'($urandom_range(0, 1)),
                  32'($urandom) & 32'hFFFF_FFFC, ($urandom_range(0, 9) < 2), h.ghr, h.ras);
      end
      applyStimulus(r, u, "rand");
    end

    $display("[TB] reset in the middle of traffic");
    for (int k = 1; k <= 4; k++)
      applyStimulus(mkReq(32'h800 + 32'(k * 16), 0,1,0,1,0,0, 32'h900), noUpd(), "fill_call");
    repeat (2) applyStimulus(idleReq(), mkUpd(32'h100, 1, 0, 1, 32'h180, 0, 8'h00, 3'd0), "retrain");
    applyStimulus(mkReq(32'h300, 0,1,0,0,0,0, 32'h400), noUpd(), "pre_reset_jal");
    #1 rst_g = 1'b0;
    #1 checkAllZero("async_reset");
    sb.delete();
    hist.delete();
    modelReset();
    @(negedge clk_g);
    @(negedge clk_g) rst_g = 1'b1;
    @(posedge clk_g); #1;
    applyStimulus(mkReq(32'h100, 1,0,0,0,0,0, 0), noUpd(), "post_reset_branch", 1, 0, 32'h104, 1, 8'h00);

    repeat (3) @(posedge clk_g);
    #1 checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
